aer_tx_ctrl_12: RTL

Synchronous controller that services the 12-taxel asynchronous arbiter tree of the spike encoder. It grants the root request, decodes which taxel won from the tree's active-low acks, and forwards the event as a 4-bit address over a 4-phase req/ack AER link to the off-chip receiver. It sits between the arbiter tree's root port and the chip's event output pads.

---
 rtl/aer_pkg.sv | 40 ++++
 rtl/sync_ff.sv | 27 ++
 rtl/aer_tx_ctrl_12.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/aer_pkg.sv
// Shared constants, state encoding and the one-hot decoder for the
// 12-taxel AER transmit controller.
package aer_pkg;

    localparam int N_TAXEL = 12;
    localparam int ADDR_W  = 4;
    localparam logic [ADDR_W-1:0] ADDR_ERR = 4'hF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        REQ     = 3'd2,
        ACK_LO  = 3'd3,
        WAIT_RO = 3'd4
    } state_e;

    // Plain vector constants so the state register stays a simple logic bus.
    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_GRANT   = GRANT;
    localparam logic [2:0] S_REQ     = REQ;
    localparam logic [2:0] S_ACK_LO  = ACK_LO;
    localparam logic [2:0] S_WAIT_RO = WAIT_RO;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] idx;
    } dec_t;

    // valid is set only for exactly one bit high; idx is ADDR_ERR for all-zero.
    function automatic dec_t onehot_to_idx(input logic [N_TAXEL-1:0] v);
        dec_t r;
        r.valid = (v != '0) && ((v & (v - 1'b1)) == '0);
        r.idx   = ADDR_ERR;
        for (int k = 0; k < N_TAXEL; k++) begin
            if (v[k]) r.idx = ADDR_W'(k);
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for asynchronous inputs.
module sync_ff #(
    parameter int                STAGES  = 2,
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [STAGES];

    // Shift the input through STAGES flops; reset loads the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) pipe[i] <= RST_VAL;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/aer_tx_ctrl_12.sv
// Grants the arbiter-tree root, decodes the winning taxel from the tree's
// active-low acks and sends it over a 4-phase req/ack AER link.
// Handshake: aer_req rises with a valid aer_addr, and is held until aer_ack
// is seen high (or the wait times out); the link then waits for aer_ack low.
module aer_tx_ctrl_12
    import aer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_MAX  = 15,
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               arb_ro,
    output logic               arb_n_ri,
    input  logic [N_TAXEL-1:0] arb_n_lno,
    output logic [ADDR_W-1:0]  aer_addr,
    output logic               aer_req,
    input  logic               aer_ack,
    output logic [CNT_W-1:0]   evt_cnt,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic               err_pulse,
    output logic               busy,
    output logic [2:0]         state
);

    localparam int TMR_MAX = (SETTLE_MAX > ACK_TIMEOUT) ? SETTLE_MAX : ACK_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    logic               arb_ro_s;
    logic               aer_ack_s;
    logic               en_s;
    logic [N_TAXEL-1:0] lno_s;
    logic [TMR_W-1:0]   timer;
    logic               prev_valid;
    logic [ADDR_W-1:0]  prev_idx;
    dec_t               dec;
    logic               settle_hit;
    logic               ack_hit;

    sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_ro_sync (
        .clk(clk), .rst(rst), .d(arb_ro), .q(arb_ro_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_ack_sync (
        .clk(clk), .rst(rst), .d(aer_ack), .q(aer_ack_s)
    );

    // en travels with arb_ro so a grant after raising en has the same latency.
    sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_en_sync (
        .clk(clk), .rst(rst), .d(en), .q(en_s)
    );

    // Acks idle high, so the synchronizer resets to "no taxel acknowledged".
    sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(N_TAXEL), .RST_VAL({N_TAXEL{1'b1}})) u_lno_sync (
        .clk(clk), .rst(rst), .d(arb_n_lno), .q(lno_s)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    assign dec        = onehot_to_idx(~lno_s);
    assign settle_hit = (timer == TMR_W'(SETTLE_MAX - 1));
    assign ack_hit    = (timer == TMR_W'(ACK_TIMEOUT - 1));
    assign busy       = (state != S_IDLE);

    // Main FSM: registered handshake outputs, per-state timer and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            arb_n_ri   <= 1'b1;
            aer_req    <= 1'b0;
            aer_addr   <= '0;
            evt_cnt    <= '0;
            drop_cnt   <= '0;
            err_pulse  <= 1'b0;
            timer      <= '0;
            prev_valid <= 1'b0;
            prev_idx   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (timer != '1) timer <= timer + 1'b1;
            case (state)
                S_IDLE: begin
                    if (en_s && arb_ro_s) begin
                        arb_n_ri   <= 1'b0;
                        prev_valid <= 1'b0;
                        timer      <= '0;
                        state      <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    prev_valid <= dec.valid;
                    prev_idx   <= dec.idx;
                    // A match on two consecutive samples wins over the settle limit.
                    if (dec.valid && prev_valid && (dec.idx == prev_idx)) begin
                        aer_addr <= dec.idx;
                        aer_req  <= 1'b1;
                        timer    <= '0;
                        state    <= S_REQ;
                    end else if (settle_hit) begin
                        aer_addr  <= ADDR_ERR;
                        err_pulse <= 1'b1;
                        drop_cnt  <= sat_inc(drop_cnt);
                        timer     <= '0;
                        state     <= S_WAIT_RO;
                    end
                end
                S_REQ: begin
                    if (aer_ack_s) begin
                        aer_req <= 1'b0;
                        evt_cnt <= sat_inc(evt_cnt);
                        timer   <= '0;
                        state   <= S_ACK_LO;
                    end else if (ack_hit) begin
                        aer_req   <= 1'b0;
                        err_pulse <= 1'b1;
                        drop_cnt  <= sat_inc(drop_cnt);
                        timer     <= '0;
                        state     <= S_ACK_LO;
                    end
                end
                S_ACK_LO: begin
                    if (!aer_ack_s || ack_hit) begin
                        timer <= '0;
                        state <= S_WAIT_RO;
                    end
                end
                S_WAIT_RO: begin
                    if (!arb_ro_s) begin
                        arb_n_ri <= 1'b1;
                        timer    <= '0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    arb_n_ri <= 1'b1;
                    aer_req  <= 1'b0;
                    timer    <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
